// File: rtl/frame_fetcher.sv
// Frame fetcher: reads a packed-RGB frame from word-addressed memory and streams
// it to the threshold processor, then waits for the processor's done pulse.
module frame_fetcher #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic [1:0]            mode_in,
  input  logic [7:0]            proc_val_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  last_data,
  output logic [1:0]            mode,
  output logic [7:0]            proc_val,
  input  logic                  proc_done,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                state;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  received;
  logic [LEN_WIDTH-1:0]  len;
  logic [ADDR_WIDTH-1:0] base;

  logic                  req_acc;
  logic                  rsp_acc;
  logic [LEN_WIDTH-1:0]  issued_nxt;
  logic [LEN_WIDTH-1:0]  received_nxt;

  // Address wraps modulo 2^ADDR_WIDTH by truncation.
  function automatic logic [ADDR_WIDTH-1:0] addr_at(input logic [ADDR_WIDTH-1:0] b,
                                                    input logic [LEN_WIDTH-1:0]  off);
    return b + ADDR_WIDTH'(off);
  endfunction

  always_comb begin
    req_acc      = (state == FETCH) && mem_req && mem_gnt;
    rsp_acc      = (state == FETCH) && mem_rvalid && (received != len);
    issued_nxt   = req_acc ? (issued + LEN_ONE) : issued;
    received_nxt = received + LEN_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      issued     <= '0;
      received   <= '0;
      len        <= '0;
      base       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      vld        <= 1'b0;
      data_in    <= '0;
      last_data  <= 1'b0;
      mode       <= '0;
      proc_val   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          vld       <= 1'b0;
          last_data <= 1'b0;
          mem_req   <= 1'b0;
          if (start) begin
            if (num_words != '0) begin
              base     <= base_addr;
              len      <= num_words;
              mode     <= mode_in;
              proc_val <= proc_val_in;
              issued   <= '0;
              received <= '0;
              mem_req  <= 1'b1;
              mem_addr <= base_addr;
              busy     <= 1'b1;
              state    <= FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          // Request side: issued never exceeds len, so != is the same as <.
          issued    <= issued_nxt;
          mem_req   <= (issued_nxt != len);
          mem_addr  <= addr_at(base, issued_nxt);
          // Return side: one registered word per rvalid, gaps pass through as vld=0.
          vld       <= rsp_acc;
          last_data <= rsp_acc && (received_nxt == len);
          if (rsp_acc) begin
            data_in  <= mem_rdata;
            received <= received_nxt;
          end
          if (vld && last_data) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          vld       <= 1'b0;
          last_data <= 1'b0;
          mem_req   <= 1'b0;
          if (proc_done) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fetcher.sv
// Self-checking bench for frame_fetcher: random/directed frames against a
// transaction-level model of requests, returned words and completion timing.
module tb_frame_fetcher;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] num_words;
  logic [1:0]    mode_in;
  logic [7:0]    proc_val_in;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          vld;
  logic [DW-1:0] data_in;
  logic          last_data;
  logic [1:0]    mode;
  logic [7:0]    proc_val;
  logic          proc_done;
  logic          busy;
  logic          frame_done;
  logic          err;

  int n_vec = 0;
  int n_mis = 0;

  frame_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .mode_in(mode_in), .proc_val_in(proc_val_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .vld(vld),
    .data_in(data_in), .last_data(last_data), .mode(mode), .proc_val(proc_val),
    .proc_done(proc_done), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_req"}, 64'(mem_req), 64'd0);
    check({tag, "_vld"}, 64'(vld), 64'd0);
  endtask

  // gmode: 0 = grant tied high, 1 = grant on odd cycles, 2 = random grant.
  // dly: cycles from the last vld to proc_done.
  task automatic run_frame(input logic [AW-1:0] base, input int n, input logic [1:0] md,
                           input logic [7:0] pv, input int gmode, input int dly);
    int grants = 0, vlds = 0, pd_cyc = -1, t = 1;
    logic acc, acc_d1 = 1'b0, acc_d2 = 1'b0, exp_req, exp_fd;
    logic [AW-1:0] acc_addr = '0;
    start = 1'b1; base_addr = base; num_words = LW'(n); mode_in = md; proc_val_in = pv;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; proc_done = 1'b0;
    tick();
    start = 1'b0; mode_in = ~md; proc_val_in = ~pv;
    forever begin
      mem_gnt    = (gmode == 0) ? 1'b1 : (gmode == 1) ? 1'(t % 2) : 1'($urandom_range(0, 1));
      mem_rvalid = acc_d1;
      mem_rdata  = acc_d1 ? mem_word(acc_addr) : $urandom;
      proc_done  = (t == 2) || (t == pd_cyc);
      start      = (t == 2);
      num_words  = (t == 2) ? '0 : LW'(n);
      @(negedge clk);
      exp_req = (grants < n);
      exp_fd  = (pd_cyc >= 0) && (t == pd_cyc + 1);
      check("mem_req", 64'(mem_req), 64'(exp_req));
      if (exp_req) check("mem_addr", 64'(mem_addr), 64'(AW'(base + AW'(grants))));
      check("vld", 64'(vld), 64'(acc_d2));
      if (acc_d2) begin
        check("data_in", 64'(data_in), 64'(mem_word(AW'(base + AW'(vlds)))));
        check("last_data", 64'(last_data), 64'(vlds == n - 1));
        vlds++;
        if (vlds == n) pd_cyc = t + dly;
      end else begin
        check("last_idle", 64'(last_data), 64'd0);
      end
      check("busy", 64'(busy), 64'(!exp_fd));
      check("frame_done", 64'(frame_done), 64'(exp_fd));
      check("err", 64'(err), 64'd0);
      check("mode", 64'(mode), 64'(md));
      check("proc_val", 64'(proc_val), 64'(pv));
      acc = exp_req && mem_gnt;
      if (acc) begin
        acc_addr = AW'(base + AW'(grants));
        grants++;
      end
      acc_d2 = acc_d1;
      acc_d1 = acc;
      if (exp_fd) break;
      if (t > 4 * n + 40) begin
        check("timeout", 64'd1, 64'd0);
        break;
      end
      tick();
      t++;
    end
    tick();
    proc_done = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    check_idle("post");
    check("post_fd", 64'(frame_done), 64'd0);
    check("hold_mode", 64'(mode), 64'(md));
    check("hold_pv", 64'(proc_val), 64'(pv));
    check("grants", 64'(grants), 64'(n));
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; mode_in = '0;
    proc_val_in = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; proc_done = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_idle("reset");
    check("reset_out", 64'({mem_addr, data_in, last_data, mode, proc_val, frame_done, err}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_frame(16'h0010, 3, 2'd1, 8'h40, 0, 4);
    run_frame(16'h0100, 1, 2'd2, 8'h11, 0, 2);
    run_frame(16'h0200, 4, 2'd3, 8'h99, 1, 1);
    run_frame(16'hFFFE, 4, 2'd0, 8'h7F, 0, 3);

    // Zero-length start is rejected with a single err pulse.
    start = 1'b1; num_words = '0; mode_in = 2'd2; proc_val_in = 8'hEE;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", 64'(err), 64'd1);
    check("err_busy", 64'(busy), 64'd0);
    check("err_mode", 64'(mode), 64'd0);
    tick();
    @(negedge clk);
    check("err_clear", 64'(err), 64'd0);
    tick();

    // Asynchronous abort mid-frame, after two of five words.
    start = 1'b1; base_addr = 16'h0300; num_words = 16'd5; mode_in = 2'd1; proc_val_in = 8'h22;
    mem_gnt = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      mem_rvalid = (c >= 2);
      mem_rdata  = mem_word(AW'(16'h0300 + AW'(c - 2)));
      tick();
    end
    check("pre_abort_busy", 64'(busy), 64'd1);
    mem_rvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_idle("abort");
    check("abort_out", 64'({mem_addr, data_in, last_data, mode, proc_val, frame_done, err}), 64'd0);
    tick();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_idle("late_rvalid");
    check("late_data", 64'(data_in), 64'd0);
    tick();
    run_frame(16'h0400, 2, 2'd2, 8'h5A, 0, 1);

    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] b;
      b = (i % 2 == 0) ? AW'($urandom) : AW'(16'hFFF8 + AW'($urandom_range(0, 7)));
      run_frame(b, $urandom_range(1, 12), 2'($urandom), 8'($urandom),
                $urandom_range(0, 2), $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
